// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes,
// FSM state enum, lane widths, and byte-enable/replication helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int BE_W   = 4;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

    // Stores only allow SB/SH/SW; loads reject the three unused codes.
    function automatic logic op_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 < 3'd3);
        else
            return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    endfunction

    // Size lives in funct3[1:0] for both signed and unsigned loads.
    function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd1:    return off[0];
            2'd2:    return (off != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the store data lets the byte enables pick the lane.
    function automatic logic [WORD_W-1:0] replicate(input logic [2:0] f3, input logic [WORD_W-1:0] d);
        case (f3[1:0])
            2'd0:    return {4{d[BYTE_W-1:0]}};
            2'd1:    return {2{d[HALF_W-1:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response channel between the LSU (master) and memory (slave).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid, we, be, addr, wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, we, be, addr, wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load lane select and sign/zero extension.
module load_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [WORD_W-1:0] result
);
    logic [WORD_W-1:0] shifted;

    // Move the addressed lane down to bit 0, then extend by load type.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = rdata;
        case (funct3)
            F3_B:    result = {{(WORD_W-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
            F3_H:    result = {{(WORD_W-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
            F3_BU:   result = {{(WORD_W-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
            F3_HU:   result = {{(WORD_W-HALF_W){1'b0}}, shifted[HALF_W-1:0]};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one op from execute, issues a single
// data-memory request, and writes aligned load data to the register file.
//
//   state | meaning
//   IDLE  | ready for a new op; illegal/misaligned ops pulse exc here
//   REQ   | memory request presented, held until mem req_ready
//   RSP   | load issued, waiting for mem rsp_valid
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    load_store_unit_if.master mem,
    output logic              rd_we,
    output logic [4:0]        rd_addr,
    output logic [31:0]       rd_data,
    output logic              busy,
    output logic              exc
);
    lsu_state_e  state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [4:0]  rd_q;
    logic [31:0] load_result;

    load_align u_load_align (
        .rdata  (mem.rsp_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    // Ready and busy follow the registered state directly.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    // Sequencer: capture, issue, and retire one memory op at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            is_store_q    <= 1'b0;
            funct3_q      <= 3'd0;
            offset_q      <= 2'd0;
            rd_q          <= 5'd0;
            mem.req_valid <= 1'b0;
            mem.we        <= 1'b0;
            mem.be        <= 4'd0;
            mem.addr      <= '0;
            mem.wdata     <= 32'd0;
            rd_we         <= 1'b0;
            rd_addr       <= 5'd0;
            rd_data       <= 32'd0;
            exc           <= 1'b0;
        end else begin
            rd_we <= 1'b0;
            exc   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        offset_q   <= req_addr[1:0];
                        rd_q       <= req_rd;
                        if (!op_legal(req_is_store, req_funct3) ||
                            op_misaligned(req_funct3, req_addr[1:0])) begin
                            exc <= 1'b1;
                        end else begin
                            state         <= REQ;
                            mem.req_valid <= 1'b1;
                            mem.we        <= req_is_store;
                            mem.be        <= calc_be(req_funct3, req_addr[1:0]);
                            mem.addr      <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem.wdata     <= replicate(req_funct3, req_wdata);
                        end
                    end
                end
                REQ: begin
                    if (mem.req_ready) begin
                        mem.req_valid <= 1'b0;
                        mem.we        <= 1'b0;
                        mem.be        <= 4'd0;
                        state         <= is_store_q ? IDLE : RSP;
                    end
                end
                RSP: begin
                    if (mem.rsp_valid) begin
                        rd_data <= load_result;
                        rd_addr <= rd_q;
                        rd_we   <= (rd_q != 5'd0);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, data-memory byte-address width (16..32).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  execute stage presents a memory op.
REQ-005 req_ready  out  1  unit accepts op; high only in IDLE.
REQ-006 req_is_store  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I size/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
REQ-008 req_addr  in  ADDR_W  effective byte address.
REQ-009 req_wdata  in  32  store data, rs2 value.
REQ-010 req_rd  in  5  load destination register.
REQ-011 mem_req_valid, mem_we, mem_be[4], mem_addr[ADDR_W], mem_wdata[32]  out  data-memory request channel.
REQ-012 mem_req_ready  in  1  memory accepts request.
REQ-013 mem_rsp_valid  in  1; mem_rsp_rdata  in  32  load response.
REQ-014 rd_we  out  1; rd_addr  out  5; rd_data  out  32  register-file write port.
REQ-015 busy  out  1  stall to pipeline; high whenever state != IDLE.
REQ-016 exc  out  1  one-cycle pulse: misaligned or illegal op.

Function
REQ-017 FSM states: IDLE, REQ, RSP.
REQ-018 IDLE: req_valid && req_ready captures all req_* fields; a legal op moves to REQ next cycle.
REQ-019 Illegal op: load funct3 in {3,6,7}, or store funct3 >= 3; causes exc=1 next cycle, no memory request, FSM stays IDLE.
REQ-020 Misaligned op: halfword with addr[0]=1, or word with addr[1:0]!=0; causes exc=1 next cycle, no memory request, FSM stays IDLE.
REQ-021 REQ: mem_req_valid=1.
REQ-022 REQ: mem_addr = captured addr with bits[1:0] forced to 0.
REQ-023 REQ: mem_we = is_store.
REQ-024 REQ mem_be: byte = 1<<addr[1:0]; half = 2'b11<<addr[1:0]; word = 4'hF.
REQ-025 REQ: all mem_* outputs held stable until mem_req_ready.
REQ-026 Store mem_wdata: byte replicated x4, half replicated x2, word as-is.
REQ-027 Store on mem_req_ready: return to IDLE; no response expected; no rd_we.
REQ-028 Load on mem_req_ready: go to RSP.
REQ-029 RSP: on mem_rsp_valid, select lane by addr[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU).
REQ-030 RSP: register the extended result into rd_data with rd_addr=rd, then return to IDLE.
REQ-031 rd_we is a one-cycle pulse in the cycle after mem_rsp_valid; it is suppressed when rd=0.
REQ-032 mem_rsp_valid in IDLE or REQ is ignored.
REQ-033 No timeout; REQ and RSP wait indefinitely.
REQ-034 Minimum load latency: accept cycle N; REQ in N+1 (ready same cycle); RSP in N+2 (rsp_valid same cycle); rd_we in N+3.
REQ-035 Minimum store latency: accept cycle N; request accepted in N+1; req_ready again in N+2.
REQ-036 Outside REQ, mem_req_valid=0 and mem_be=0.

Reset
REQ-037 On rst_n low, asynchronously: state=IDLE, captured fields=0, all outputs 0 (req_ready=1 once FSM is IDLE).
REQ-038 Reset mid-REQ or mid-RSP abandons the transaction; no rd_we and no exc follow.

Structure
REQ-039 Shared package lsu_pkg holds: funct3 encoding constants; the lsu_state_e enum (IDLE, REQ, RSP); the be/replication width constants.
REQ-040 One combinational sub-module, load_align, performs lane select and extension from (rdata, offset, funct3).

Verification
REQ-041 LW addr 0x100, rd=5, ready immediate, rdata 0xDEADBEEF -> mem_addr 0x100, be 0xF; rd_we pulse, rd_addr 5, rd_data 0xDEADBEEF at N+3.
REQ-042 LB addr 0x103, rdata 0x80000000 -> be 0x8, rd_data 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-043 SH addr 0x202, wdata 0x1234ABCD, mem_req_ready delayed 3 cycles -> be 0xC, wdata 0xABCDABCD held stable 4 cycles; no rd_we.
REQ-044 LW addr 0x101 and SH addr 0x001 -> exc pulse each, mem_req_valid never asserted.
REQ-045 LW with rd=0 -> memory transaction completes, rd_we stays 0.
REQ-046 rst_n low in RSP, then a late mem_rsp_valid -> no rd_we; busy=0; req_ready=1.
